serial_deserializer: RTL

- Downstream consumer of a D flip-flop's sampled output stream: one bit per accepted clock edge.
- Assembles WIDTH consecutive bits into a parallel word.
- Holds each finished word in a one-deep output register with a valid/ready handshake.
- Applies backpressure on the serial side when the output register and the shift register are both full. Sits between the single-bit storage stage and the word-level datapath.

---
 rtl/serial_deserializer_if.sv | 34 +++
 rtl/serial_deserializer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deserializer_if
//  Brief    : Serial-in / word-out bus bundle for serial_deserializer.
//             master = side that feeds bits and consumes words,
//             slave  = the deserializer itself.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int c_CW = $clog2(WIDTH) + 1;

    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [c_CW-1:0]  bit_count;
    logic [7:0]       word_count;

    modport master (
        output sin, sin_valid, flush, out_ready,
        input  sin_ready, out_data, out_valid, bit_count, word_count
    );

    modport slave (
        input  sin, sin_valid, flush, out_ready,
        output sin_ready, out_data, out_valid, bit_count, word_count
    );
endinterface
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deserializer
//  Brief    : Collects WIDTH serial bits into a word, holds it in a one-deep
//             valid/ready output register and stalls the serial side while
//             both the shift register and the output register are full.
//  Revision : 1.0  initial release
// ============================================================================
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    serial_deserializer_if.slave   bus
);
    localparam int c_CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_STALL = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [c_CW-1:0]  r_bit_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [7:0]       r_word_count;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_sin_ready;
    logic             w_accept;
    logic             w_complete;
    logic             w_out_free;
    logic             w_load_fill;
    logic             w_load_stall;
    logic             w_load;

    // Bit order of the assembled word is fixed at elaboration.
    if (MSB_FIRST) begin : g_msb_first
        assign w_shift_next = {r_shift[WIDTH-2:0], bus.sin};
    end else begin : g_lsb_first
        assign w_shift_next = {bus.sin, r_shift[WIDTH-1:1]};
    end

    // A flush on the same edge throws the offered bit away, so it never completes a word.
    assign w_accept     = bus.sin_valid && w_sin_ready;
    assign w_complete   = w_accept && !bus.flush && (r_bit_count == c_CW'(WIDTH - 1));
    assign w_out_free   = !r_out_valid || bus.out_ready;
    assign w_load_fill  = w_complete && w_out_free;
    assign w_load_stall = (r_state == c_STALL) && bus.out_ready && !bus.flush;
    assign w_load       = w_load_fill || w_load_stall;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: park in STALL when a finished word cannot move to the output register.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_FILL: begin
                if (w_complete && !w_out_free) begin
                    w_state_next = c_STALL;
                end
            end
            c_STALL: begin
                if (bus.flush || bus.out_ready) begin
                    w_state_next = c_FILL;
                end
            end
            default: w_state_next = c_FILL;
        endcase
    end

    // FSM outputs: serial side is open only while filling and out of reset.
    always_comb begin
        w_sin_ready = 1'b0;
        if (reset_n && (r_state == c_FILL)) begin
            w_sin_ready = 1'b1;
        end
    end

    // Shift register and fill level; cleared whenever its word leaves or is flushed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_shift     <= '0;
            r_bit_count <= '0;
        end else if (bus.flush) begin
            r_shift     <= '0;
            r_bit_count <= '0;
        end else if (w_load) begin
            r_shift     <= '0;
            r_bit_count <= '0;
        end else if (w_accept) begin
            r_shift     <= w_shift_next;
            r_bit_count <= r_bit_count + c_CW'(1);
        end
    end

    // Output register: load a finished word, otherwise drop valid once delivered.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
        end else if (w_load) begin
            r_out_data   <= (r_state == c_STALL) ? r_shift : w_shift_next;
            r_out_valid  <= 1'b1;
            r_word_count <= r_word_count + 8'd1;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.sin_ready  = w_sin_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.bit_count  = r_bit_count;
    assign bus.word_count = r_word_count;

endmodule
`default_nettype wire
